// File: rtl/spram_ctrl_if.sv
// Request/response bus of spram_ctrl: one request channel, one read-response strobe.
// The requester uses the master modport; the controller uses the slave modport.
interface spram_ctrl_if #(
  parameter int data_width = 8,
  parameter int addr_width = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [addr_width-1:0] req_addr;
  logic [data_width-1:0] req_wdata;
  logic                  rsp_valid;
  logic [data_width-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/spram_ctrl.sv
// Single-port RAM controller: serialises reads/writes onto registered RAM pins.
// Optional memory clear sweep is built only when SPRAM_CTRL_CLEAR_EN is defined.
module spram_ctrl #(
  parameter int data_width = 8,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spram_ctrl_if.slave           bus,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_data_in,
  input  logic [data_width-1:0] ram_data_out
);

`ifdef SPRAM_CTRL_CLEAR_EN
  typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR, RD, RD_CAP} state_t;
`endif

  state_t                state_reg, state_next;
  logic                  ram_we_reg, ram_we_next;
  logic [addr_width-1:0] ram_addr_reg, ram_addr_next;
  logic [data_width-1:0] ram_data_in_reg, ram_data_in_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [data_width-1:0] rsp_rdata_reg, rsp_rdata_next;

`ifdef SPRAM_CTRL_CLEAR_EN
  // One extra bit lets the sweep end on a clean compare against 2^addr_width.
  localparam logic [addr_width:0] CLR_END = {1'b1, {addr_width{1'b0}}};

  logic                  clr_busy_reg, clr_busy_next;
  logic                  clr_done_reg, clr_done_next;
  logic [addr_width:0]   cnt_reg, cnt_next;
  logic [addr_width:0]   cnt_inc;

  assign cnt_inc       = cnt_reg + 1'b1;
  assign bus.req_ready = (state_reg == IDLE) && !clr_start;
  assign clr_busy      = clr_busy_reg;
  assign clr_done      = clr_done_reg;
`else
  logic unused_clr_start;

  assign unused_clr_start = clr_start;
  assign bus.req_ready    = (state_reg == IDLE);
  assign clr_busy         = 1'b0;
  assign clr_done         = 1'b0;
`endif

  assign ram_we        = ram_we_reg;
  assign ram_addr      = ram_addr_reg;
  assign ram_data_in   = ram_data_in_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;

  always_comb begin
    state_next       = state_reg;
    ram_we_next      = 1'b0;
    ram_addr_next    = ram_addr_reg;
    ram_data_in_next = ram_data_in_reg;
    rsp_valid_next   = 1'b0;
    rsp_rdata_next   = rsp_rdata_reg;
`ifdef SPRAM_CTRL_CLEAR_EN
    clr_busy_next    = 1'b0;
    clr_done_next    = 1'b0;
    cnt_next         = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
`ifdef SPRAM_CTRL_CLEAR_EN
        if (clr_start) begin
          state_next       = CLEAR;
          ram_we_next      = 1'b1;
          ram_addr_next    = '0;
          ram_data_in_next = '0;
          clr_busy_next    = 1'b1;
          cnt_next         = '0;
        end else
`endif
        if (bus.req_valid) begin
          ram_addr_next = bus.req_addr;
          if (bus.req_we) begin
            state_next       = WR;
            ram_we_next      = 1'b1;
            ram_data_in_next = bus.req_wdata;
          end else begin
            state_next = RD;
          end
        end
      end
      WR:     state_next = IDLE;
      RD:     state_next = RD_CAP;
      // RAM read data is valid here, one edge after the address was presented.
      RD_CAP: begin
        state_next     = IDLE;
        rsp_valid_next = 1'b1;
        rsp_rdata_next = ram_data_out;
      end
`ifdef SPRAM_CTRL_CLEAR_EN
      CLEAR: begin
        if (cnt_inc == CLR_END) begin
          state_next    = IDLE;
          clr_done_next = 1'b1;
          cnt_next      = '0;
        end else begin
          ram_we_next      = 1'b1;
          ram_addr_next    = cnt_inc[addr_width-1:0];
          ram_data_in_next = '0;
          clr_busy_next    = 1'b1;
          cnt_next         = cnt_inc;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ram_we_reg      <= 1'b0;
      ram_addr_reg    <= '0;
      ram_data_in_reg <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
`ifdef SPRAM_CTRL_CLEAR_EN
      clr_busy_reg    <= 1'b0;
      clr_done_reg    <= 1'b0;
      cnt_reg         <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      ram_we_reg      <= ram_we_next;
      ram_addr_reg    <= ram_addr_next;
      ram_data_in_reg <= ram_data_in_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
`ifdef SPRAM_CTRL_CLEAR_EN
      clr_busy_reg    <= clr_busy_next;
      clr_done_reg    <= clr_done_next;
      cnt_reg         <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_spram_ctrl.sv
// Scoreboard bench for spram_ctrl with a behavioural registered-read RAM.
// Clear-engine scenarios run only when SPRAM_CTRL_CLEAR_EN is defined.
module tb_spram_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic [DW-1:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            at;
    string         name;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spram_ctrl_if #(.data_width(DW), .addr_width(AW)) bus ();

  spram_ctrl #(.data_width(DW), .addr_width(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .clr_start    (clr_start),
    .clr_busy     (clr_busy),
    .clr_done     (clr_done),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // Downstream RAM: registered read, output held during writes.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    else        ram_data_out  <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", nm, act, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit expect_rsp, input string nm);
    int budget = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.req_ready) begin
      timeout({nm, "_accept"});
      bus.req_valid = 1'b0;
      return;
    end
    if (!we && expect_rsp) exp_q.push_back('{data: d, at: cyc + 3, name: nm});
    $display("req  %s: we=%0b addr=%0d wdata=0x%0h accepted at edge %0d", nm, we, a, d, cyc + 1);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) timeout("rsp_drain");
    @(negedge clk);
  endtask

  task automatic count_not_ready(output int n);
    n = 0;
    while (!bus.req_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int i = 0; i < 16; i++) do_req(1'b1, AW'(i), v, 1'b0, "fill");
    idle();
    @(negedge clk);
  endtask

  // Monitor: every response must match the oldest outstanding read.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_rdata=0x%0h, required no response", bus.rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_data"}, 32'(bus.rsp_rdata), 32'(e.data));
          chk({e.name, "_latency"}, cyc, e.at);
        end
      end
    end
  end

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    clr_start     = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_data_in", 32'(ram_data_in), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_clr_done", 32'(clr_done), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 0xA5 to 3: one-cycle ram_we pulse, then read it back.
    do_req(1'b1, 4'd3, 8'hA5, 1'b0, "wr3");
    idle();
    chk("wr3_ram_we", 32'(ram_we), 1);
    chk("wr3_ram_addr", 32'(ram_addr), 3);
    chk("wr3_ram_data_in", 32'(ram_data_in), 32'hA5);
    @(negedge clk);
    chk("wr3_ram_we_end", 32'(ram_we), 0);
    do_req(1'b0, 4'd3, 8'hA5, 1'b1, "rd3");
    idle();
    chk("rd3_ram_we", 32'(ram_we), 0);
    drain();
    chk("rsp_rdata_held", 32'(bus.rsp_rdata), 32'hA5);

    // Back-to-back writes then back-to-back reads with req_valid held.
    do_req(1'b1, 4'd1, 8'h11, 1'b0, "wr1");
    count_not_ready(n);
    chk("wr_gap_cycles", n, 1);
    do_req(1'b1, 4'd2, 8'h22, 1'b0, "wr2");
    do_req(1'b0, 4'd1, 8'h11, 1'b1, "rd1");
    count_not_ready(n);
    chk("rd_gap_cycles", n, 2);
    do_req(1'b0, 4'd2, 8'h22, 1'b1, "rd2");
    idle();
    drain();

    // Reset mid-read: no response may appear afterwards.
    do_req(1'b0, 4'd1, 8'h00, 1'b0, "rd_abort");
    idle();
    rst_n = 1'b0;
    #1;
    chk("abort_ram_addr", 32'(ram_addr), 0);
    chk("abort_rsp_rdata", 32'(bus.rsp_rdata), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_rsp", 32'(bus.rsp_valid), 0);

`ifdef SPRAM_CTRL_CLEAR_EN
    // Full sweep after filling with 0xFF.
    fill(8'hFF);
    clr_start = 1'b1;
    chk("clr_gates_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    clr_start = 1'b0;
    n = 0;
    while (clr_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("clr_busy_cycles", n, 16);
    chk("clr_done_pulse", 32'(clr_done), 1);
    @(negedge clk);
    chk("clr_done_end", 32'(clr_done), 0);
    do_req(1'b0, 4'd0, 8'h00, 1'b1, "rd0_cleared");
    do_req(1'b0, 4'd15, 8'h00, 1'b1, "rd15_cleared");
    idle();
    drain();

    // clr_start beats a simultaneous write; write lands after the sweep.
    clr_start     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 4'd5;
    bus.req_wdata = 8'h77;
    chk("clr_vs_req_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    clr_start = 1'b0;
    chk("clr_vs_req_busy", 32'(clr_busy), 1);
    do_req(1'b1, 4'd5, 8'h77, 1'b0, "wr5_after_clr");
    idle();
    chk("wr5_after_clr_busy", 32'(clr_busy), 0);
    @(negedge clk);
    do_req(1'b0, 4'd5, 8'h77, 1'b1, "rd5");
    // clr_start while a read is in flight is ignored.
    idle();
    clr_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr_start = 1'b0;
    chk("clr_ignored_busy", 32'(clr_busy), 0);
    drain();
    chk("clr_ignored_busy_after", 32'(clr_busy), 0);

    // Reset at sweep address 7 aborts the clear.
    fill(8'hFF);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    n = 0;
    while (!(clr_busy && ram_addr == 4'd7) && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) timeout("sweep_reach_7");
    rst_n = 1'b0;
    #1;
    chk("rst7_ram_we", 32'(ram_we), 0);
    chk("rst7_ram_addr", 32'(ram_addr), 0);
    chk("rst7_ram_data_in", 32'(ram_data_in), 0);
    chk("rst7_clr_busy", 32'(clr_busy), 0);
    chk("rst7_clr_done", 32'(clr_done), 0);
    chk("rst7_rsp_valid", 32'(bus.rsp_valid), 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (clr_done) n++;
    end
    chk("rst7_no_clr_done", n, 0);
    do_req(1'b0, 4'd6, 8'h00, 1'b1, "rd6_cleared");
    do_req(1'b0, 4'd7, 8'hFF, 1'b1, "rd7_kept");
    do_req(1'b0, 4'd8, 8'hFF, 1'b1, "rd8_kept");
    do_req(1'b0, 4'd15, 8'hFF, 1'b1, "rd15_kept");
    idle();
    drain();
`else
    // clr_start has no effect without the clear engine.
    clr_start = 1'b1;
    chk("noclr_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    clr_start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (clr_busy || clr_done || ram_we) n++;
      @(negedge clk);
    end
    chk("noclr_no_activity", n, 0);
    do_req(1'b0, 4'd3, 8'hA5, 1'b1, "rd3_unchanged");
    do_req(1'b0, 4'd2, 8'h22, 1'b1, "rd2_unchanged");
    idle();
    drain();
    clr_start = 1'b1;
    do_req(1'b1, 4'd6, 8'h66, 1'b0, "wr6_with_clr_start");
    clr_start = 1'b0;
    idle();
    chk("wr6_ram_we", 32'(ram_we), 1);
    chk("wr6_clr_busy", 32'(clr_busy), 0);
    @(negedge clk);
    do_req(1'b0, 4'd6, 8'h66, 1'b1, "rd6");
    idle();
    drain();
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spram_ctrl.md
SPRAM_CTRL -- requirements
Module: spram_ctrl

Interface
REQ-001 SHALL have parameter data_width, default 8, meaning word width in bits.
REQ-002 SHALL have parameter addr_width, default 4, meaning address width; depth = 2^addr_width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  addr_width  request address.
REQ-009 SHALL have port req_wdata  input  data_width  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle read-response strobe.
REQ-011 SHALL have port rsp_rdata  output  data_width  read data, held until next response.
REQ-012 SHALL have port clr_start  input  1  start memory clear sweep.
REQ-013 SHALL have port clr_busy  output  1  clear sweep in progress.
REQ-014 SHALL have port clr_done  output  1  one-cycle pulse when the sweep completes.
REQ-015 SHALL have ports ram_we, ram_addr, ram_data_in  outputs  1/addr_width/data_width, all registered, driving the downstream single-port RAM (write-enable, address, write data).
REQ-016 SHALL have port ram_data_out  input  data_width  RAM registered read data (1-cycle latency, held while RAM is writing).

Function
REQ-017 SHALL implement FSM states IDLE, WR, RD, RD_CAP, CLEAR.
REQ-018 SHALL drive req_ready = (state==IDLE) && !clr_start, combinationally.
REQ-019 On write accept: next state WR with ram_we=1, ram_addr=req_addr, ram_data_in=req_wdata for exactly one cycle, then IDLE.
REQ-020 On read accept (edge E0): state RD with ram_we=0, ram_addr=req_addr; at E1 state RD_CAP; at E2 rsp_rdata<=ram_data_out, rsp_valid=1 for one cycle, state IDLE.
REQ-021 Sustained throughput: 1 write per 2 cycles, 1 read per 3 cycles; no request is dropped or reordered.
REQ-022 ram_we SHALL be 0 in every state except WR and CLEAR.
REQ-023 clr_start in IDLE SHALL win over a simultaneous req_valid (request not accepted that cycle) and enter CLEAR.
REQ-024 CLEAR SHALL write 0 to addresses 0,1,...,2^addr_width-1, one per cycle, ram_we=1, clr_busy=1 throughout.
REQ-025 After the last address write, state IDLE, clr_busy=0, and clr_done=1 for one cycle.
REQ-026 clr_start outside IDLE SHALL be ignored.
REQ-027 Address counter SHALL be addr_width+1 bits so the last address terminates without wrap ambiguity.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, ram_we=0, ram_addr=0, ram_data_in=0, rsp_valid=0, rsp_rdata=0, clr_busy=0, clr_done=0, counter=0.
REQ-029 Reset during CLEAR or a read SHALL abort it; no resumption, no rsp_valid or clr_done pulse.

Configuration
REQ-030 Macro SPRAM_CTRL_CLEAR_EN defined: clear engine per REQ-023..REQ-027 present.
REQ-031 SPRAM_CTRL_CLEAR_EN undefined: CLEAR state omitted, clr_start ignored (not gating req_ready), clr_busy and clr_done tied 0; ports retained.

Verification (data_width=8, addr_width=4)
REQ-032 Write 0xA5 to addr 3, then read addr 3 -> ram_we pulse 1 cycle with addr 3; rsp_valid 3 cycles after read accept, rsp_rdata=0xA5.
REQ-033 Back-to-back reads addr 1 (0x11), addr 2 (0x22), req_valid held -> two rsp_valid pulses, data 0x11 then 0x22, req_ready low 2 cycles between accepts.
REQ-034 With SPRAM_CTRL_CLEAR_EN: fill all 16 with 0xFF, clr_start -> clr_busy high 16 cycles, clr_done pulse, reads of addr 0 and 15 return 0x00.
REQ-035 clr_start and req_valid (write 0x77 to addr 5) same cycle -> write not accepted until clear done, then accepted; addr 5 reads 0x77.
REQ-036 rst_n low at sweep address 7 -> all outputs zero immediately, no clr_done, addrs 8..15 retain old contents.
REQ-037 Without SPRAM_CTRL_CLEAR_EN: clr_start pulse -> clr_busy stays 0, req_ready unaffected, memory unchanged.
